// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// master = datapath side (supplies opcode/flags/ready), slave = controller.
interface multicycle_ctrl_if #(
  parameter int OPW  = 4,
  parameter int MMW  = 4,
  parameter int STW  = 4,
  parameter int CNTW = 16
);
  logic [OPW-1:0]  OPCODE;
  logic [MMW-1:0]  MM;
  logic [STW-1:0]  STAT;
  logic            MEM_RDY;
  logic            RF_WE;
  logic [1:0]      ALU_OP;
  logic            WB_SEL;
  logic            RD_SEL;
  logic            PC_SEL;
  logic            PC_WRITE;
  logic            PC_RST;
  logic            BR_SEL;
  logic            MEM_REQ;
  logic            MEM_WE;
  logic            HALTED;
  logic [2:0]      STATE;
  logic [CNTW-1:0] INSTR_CNT;

  modport master (
    output OPCODE, MM, STAT, MEM_RDY,
    input  RF_WE, ALU_OP, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL,
           MEM_REQ, MEM_WE, HALTED, STATE, INSTR_CNT
  );

  modport slave (
    input  OPCODE, MM, STAT, MEM_RDY,
    output RF_WE, ALU_OP, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL,
           MEM_REQ, MEM_WE, HALTED, STATE, INSTR_CNT
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: 5 cycles per instruction plus MEM stall cycles; outputs are
// combinational from the present state. MEM holds on !MEM_RDY for loads/stores only.
module multicycle_ctrl #(
  parameter int OPW         = 4,
  parameter int MMW         = 4,
  parameter int STW         = 4,
  parameter int CNTW        = 16,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic              CLK,
  input logic              RST_F,
  multicycle_ctrl_if.slave bus
);
  localparam logic [2:0] S_START0    = 3'd0;
  localparam logic [2:0] S_START1    = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_EXECUTE   = 3'd4;
  localparam logic [2:0] S_MEM       = 3'd5;
  localparam logic [2:0] S_WRITEBACK = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [OPW-1:0] OP_LOD = OPW'(1);
  localparam logic [OPW-1:0] OP_STR = OPW'(2);
  localparam logic [OPW-1:0] OP_BRA = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6);
  localparam logic [OPW-1:0] OP_ALU = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [CNTW-1:0] r_cnt;
  logic [STW-1:0]  w_mask;
  logic            w_is_mem;
  logic            w_is_alu;
  logic            w_is_brr;
  logic            w_mm_reg;
  logic            w_mm_imm;
  logic            w_taken;

  assign w_mask   = bus.MM[STW-1:0];
  assign w_is_mem = (bus.OPCODE == OP_LOD) || (bus.OPCODE == OP_STR);
  assign w_is_alu = (bus.OPCODE == OP_ALU);
  assign w_is_brr = (bus.OPCODE == OP_BRR);
  assign w_mm_reg = (bus.MM == MMW'(0));
  assign w_mm_imm = (bus.MM == MMW'(8));

  // BNE needs every masked flag clear; BRA/BRR need every masked flag set.
  always_comb begin
    w_taken = 1'b0;
    if (bus.OPCODE == OP_BNE)
      w_taken = ((bus.STAT & w_mask) == '0);
    else if ((bus.OPCODE == OP_BRA) || w_is_brr)
      w_taken = ((bus.STAT & w_mask) == w_mask);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START0:    w_next = S_START1;
      S_START1:    w_next = S_FETCH;
      S_FETCH:     w_next = S_DECODE;
      S_DECODE:    w_next = (bus.OPCODE == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   w_next = S_MEM;
      S_MEM:       w_next = (w_is_mem && MEM_WAIT_EN && !bus.MEM_RDY) ? S_MEM : S_WRITEBACK;
      S_WRITEBACK: w_next = S_FETCH;
      default:     w_next = S_HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_state <= S_START0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WRITEBACK)
        r_cnt <= r_cnt + CNTW'(1);
    end
  end

  always_comb begin
    bus.RF_WE    = 1'b0;
    bus.ALU_OP   = 2'b00;
    bus.WB_SEL   = 1'b0;
    bus.RD_SEL   = 1'b0;
    bus.PC_SEL   = 1'b0;
    bus.PC_WRITE = 1'b0;
    bus.BR_SEL   = 1'b0;
    bus.MEM_REQ  = 1'b0;
    bus.MEM_WE   = 1'b0;
    // Reset drives PC_RST directly so the PC clears even before the state flop settles.
    bus.PC_RST   = !RST_F || (r_state == S_START0) || (r_state == S_START1);
    bus.HALTED   = (r_state == S_HALT);
    bus.STATE    = r_state;
    bus.INSTR_CNT = r_cnt;
    case (r_state)
      S_FETCH: bus.PC_WRITE = 1'b1;
      S_EXECUTE: begin
        bus.BR_SEL = w_is_brr;
        if (w_is_alu)
          bus.ALU_OP = w_mm_reg ? 2'b00 : (w_mm_imm ? 2'b01 : 2'b11);
        else if (w_is_mem || w_is_brr)
          bus.ALU_OP = 2'b10;
        else if ((bus.OPCODE == OP_BRA) || (bus.OPCODE == OP_BNE))
          bus.ALU_OP = 2'b11;
      end
      S_MEM: begin
        bus.BR_SEL  = w_is_brr;
        bus.MEM_REQ = w_is_mem;
        bus.MEM_WE  = (bus.OPCODE == OP_STR);
      end
      S_WRITEBACK: begin
        bus.BR_SEL   = w_is_brr;
        bus.PC_SEL   = w_taken;
        bus.PC_WRITE = w_taken;
        if (w_is_alu) begin
          bus.RF_WE  = 1'b1;
          bus.RD_SEL = w_mm_reg;
        end else if (bus.OPCODE == OP_LOD) begin
          bus.RF_WE  = 1'b1;
          bus.WB_SEL = 1'b1;
          bus.RD_SEL = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three instances (default, no memory wait, 2-bit counter)
// checked cycle by cycle against a per-instruction schedule model.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic       rf_we;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic       rd_sel;
    logic       pc_sel;
    logic       pc_write;
    logic       pc_rst;
    logic       br_sel;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
  } outs_t;

  logic        clk;
  logic        rstn    [3];
  logic [3:0]  op_q    [3];
  logic [3:0]  mm_q    [3];
  logic [3:0]  stat_q  [3];
  logic        mrdy_q  [3];
  outs_t       obs     [3];
  logic [15:0] cnt_obs [3];
  int          cnt_model [3];
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 16;
    localparam bit WE = (g == 1) ? 1'b0 : 1'b1;
    multicycle_ctrl_if #(.CNTW(CW)) bus ();
    multicycle_ctrl #(.CNTW(CW), .MEM_WAIT_EN(WE)) dut (
      .CLK   (clk),
      .RST_F (rstn[g]),
      .bus   (bus)
    );
    assign bus.OPCODE  = op_q[g];
    assign bus.MM      = mm_q[g];
    assign bus.STAT    = stat_q[g];
    assign bus.MEM_RDY = mrdy_q[g];
    assign obs[g] = {bus.STATE, bus.RF_WE, bus.ALU_OP, bus.WB_SEL, bus.RD_SEL, bus.PC_SEL,
                     bus.PC_WRITE, bus.PC_RST, bus.BR_SEL, bus.MEM_REQ, bus.MEM_WE, bus.HALTED};
    assign cnt_obs[g] = 16'(bus.INSTR_CNT);
  end

  function automatic logic [15:0] cmask(input int d);
    return (d == 2) ? 16'h0003 : 16'hFFFF;
  endfunction

  task automatic check(input int d, input outs_t e, input string tag, input bit wait_neg);
    logic [15:0] ecnt;
    if (wait_neg) @(negedge clk);
    ecnt = 16'(cnt_model[d]) & cmask(d);
    checks++;
    assert (obs[d] === e) else begin
      errors++;
      $error("FAIL %s dut%0d: outputs=%h expected=%h", tag, d, obs[d], e);
    end
    checks++;
    assert (cnt_obs[d] === ecnt) else begin
      errors++;
      $error("FAIL %s_cnt dut%0d: count=%0d expected=%0d", tag, d, cnt_obs[d], ecnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse: async effect, 3 held cycles, release, then START0/START1; ends in FETCH.
  task automatic rst_seq(input int d);
    outs_t e;
    rstn[d] = 1'b0;
    cnt_model[d] = 0;
    e = '0; e.pc_rst = 1'b1;
    #1 check(d, e, "rst_async", 1'b0);
    repeat (3) check(d, e, "rst_hold", 1'b1);
    @(posedge clk); #1;
    rstn[d] = 1'b1;
    e = '0; e.st = 3'd0; e.pc_rst = 1'b1;
    check(d, e, "start0", 1'b1); tick();
    e.st = 3'd1;
    check(d, e, "start1", 1'b1); tick();
  endtask

  // One instruction from FETCH; abort_at >= 0 pulls reset during that MEM cycle.
  task automatic exec(input int d, input logic [3:0] op, input logic [3:0] mm,
                      input logic [3:0] st, input int stalls, input int abort_at);
    outs_t e;
    bit    memop, branch, taken, waits;
    int    n;
    memop  = (op == 4'd1) || (op == 4'd2);
    branch = (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    taken  = (op == 4'd6) ? ((st & mm) == 4'd0) : ((st & mm) == mm);
    waits  = memop && (d != 1);
    op_q[d] = op; mm_q[d] = mm; stat_q[d] = st; mrdy_q[d] = 1'($urandom);

    e = '0; e.st = 3'd2; e.pc_write = 1'b1;
    check(d, e, "fetch", 1'b1); tick();
    e = '0; e.st = 3'd3;
    check(d, e, "decode", 1'b1); tick();
    if (op == 4'd15) begin
      repeat (22) begin
        mrdy_q[d] = 1'($urandom);
        e = '0; e.st = 3'd7; e.halted = 1'b1;
        check(d, e, "halt", 1'b1); tick();
      end
      return;
    end

    e = '0; e.st = 3'd4; e.br_sel = (op == 4'd5);
    if (op == 4'd8)            e.alu_op = (mm == 4'd0) ? 2'd0 : ((mm == 4'd8) ? 2'd1 : 2'd3);
    else if (memop || op == 5) e.alu_op = 2'd2;
    else if (branch)           e.alu_op = 2'd3;
    check(d, e, "execute", 1'b1); tick();

    n = waits ? stalls + 1 : 1;
    for (int i = 0; i < n; i++) begin
      mrdy_q[d] = waits ? (i >= stalls) : 1'($urandom);
      e = '0; e.st = 3'd5; e.br_sel = (op == 4'd5);
      e.mem_req = memop; e.mem_we = (op == 4'd2);
      check(d, e, "mem", 1'b1);
      if (i == abort_at) begin
        #1 rstn[d] = 1'b0;
        cnt_model[d] = 0;
        e = '0; e.pc_rst = 1'b1;
        #1 check(d, e, "mem_abort", 1'b0);
        return;
      end
      tick();
    end

    e = '0; e.st = 3'd6; e.br_sel = (op == 4'd5);
    e.rf_we  = (op == 4'd8) || (op == 4'd1);
    e.wb_sel = (op == 4'd1);
    e.rd_sel = (op == 4'd8) ? (mm == 4'd0) : (op == 4'd1);
    e.pc_sel = branch && taken;
    e.pc_write = branch && taken;
    check(d, e, "writeback", 1'b1); tick();
    cnt_model[d]++;
  endtask

  task automatic random_run(input int d, input int count);
    logic [3:0] op, mm;
    for (int k = 0; k < count; k++) begin
      op = 4'($urandom_range(0, 14));
      case ($urandom_range(0, 2))
        0:       mm = 4'd0;
        1:       mm = 4'd8;
        default: mm = 4'($urandom);
      endcase
      exec(d, op, mm, 4'($urandom), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; op_q[d] = '0; mm_q[d] = '0; stat_q[d] = '0; mrdy_q[d] = 1'b0;
      cnt_model[d] = 0;
    end

    rst_seq(0);
    exec(0, 4'd8, 4'd0, 4'd0, 0, -1);
    exec(0, 4'd8, 4'd8, 4'd0, 0, -1);
    exec(0, 4'd8, 4'd3, 4'd0, 0, -1);
    exec(0, 4'd1, 4'd0, 4'd0, 3, -1);
    exec(0, 4'd2, 4'd0, 4'd0, 0, -1);
    exec(0, 4'd0, 4'd0, 4'd0, 0, -1);
    exec(0, 4'd3, 4'd0, 4'd0, 2, -1);
    exec(0, 4'd6, 4'd1, 4'd1, 0, -1);
    exec(0, 4'd6, 4'd1, 4'd0, 0, -1);
    exec(0, 4'd5, 4'd0, 4'd0, 0, -1);
    exec(0, 4'd4, 4'd3, 4'd1, 0, -1);
    exec(0, 4'd4, 4'd3, 4'd7, 0, -1);
    random_run(0, 40);
    exec(0, 4'd2, 4'd0, 4'd0, 5, 2);
    rst_seq(0);
    exec(0, 4'd8, 4'd0, 4'd0, 0, -1);
    exec(0, 4'd15, 4'd0, 4'd0, 0, -1);
    rst_seq(0);
    exec(0, 4'd0, 4'd0, 4'd0, 0, -1);

    rst_seq(1);
    exec(1, 4'd1, 4'd0, 4'd0, 3, -1);
    exec(1, 4'd2, 4'd0, 4'd0, 3, -1);
    random_run(1, 20);

    rst_seq(2);
    repeat (6) exec(2, 4'd0, 4'd0, 4'd0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised multicycle CPU control FSM and the next generation of the existing start/fetch/decode/execute/mem/writeback controller. It adds a memory-ready handshake with stall in MEM, a real HALT state, and flag-conditioned branches. It also adds load/store strobes and a retired-instruction counter. It sits between the instruction register/status register and the PC, register file, ALU and data memory.

Parameters:
OPW, 4, opcode width (opcode values below are zero-extended to OPW)
MMW, 4, addressing-mode/condition-mask field width
STW, 4, status flag width; STW <= MMW; mask = MM[STW-1:0]
CNTW, 16, retired-instruction counter width
MEM_WAIT_EN, 1, 1 = MEM waits for MEM_RDY; 0 = MEM is always exactly one cycle

Ports:
CLK  in  1  clock, rising edge
RST_F  in  1  asynchronous active-low reset
OPCODE  in  OPW  current instruction opcode, stable from DECODE through WRITEBACK
MM  in  MMW  addressing mode (ALU: 0 = reg, 8 = imm) / branch condition mask
STAT  in  STW  ALU status flags
MEM_RDY  in  1  data memory completion
RF_WE  out  1  register file write enable
ALU_OP  out  2  00 = reg-reg, 01 = reg-imm, 10 = address add (LOD/STR/BRR), 11 = pass
WB_SEL  out  1  0 = ALU result, 1 = memory data
RD_SEL  out  1  1 = register operand form, 0 = immediate form
PC_SEL  out  1  1 = branch target, 0 = PC+1
PC_WRITE  out  1  PC load strobe
PC_RST  out  1  PC reset
BR_SEL  out  1  1 = relative target (BRR), 0 = absolute (BRA/BNE)
MEM_REQ  out  1  data memory request
MEM_WE  out  1  data memory write
HALTED  out  1  FSM in HALT
STATE  out  3  present state encoding (debug)
INSTR_CNT  out  CNTW  retired instruction count

Behaviour:
- Opcodes: NOOP 0, LOD 1, STR 2, BRA 4, BRR 5, BNE 6, ALU 8, HLT 15. Any other opcode is treated as NOOP.
- States and STATE encoding: START0 = 0, START1 = 1, FETCH = 2, DECODE = 3, EXECUTE = 4, MEM = 5, WRITEBACK = 6, HALT = 7.
- Transitions:
  - START0 -> START1 -> FETCH -> DECODE.
  - DECODE -> HALT if OPCODE == HLT, else -> EXECUTE.
  - EXECUTE -> MEM.
  - MEM holds while (OPCODE is LOD/STR and MEM_WAIT_EN and !MEM_RDY), else -> WRITEBACK. Non-memory opcodes spend exactly one cycle in MEM.
  - WRITEBACK -> FETCH.
  - HALT -> HALT; leaves only through reset.
- Reset:
  - RST_F low forces state START0 immediately (asynchronous), independent of CLK.
  - INSTR_CNT clears to 0 on reset.
  - Reset asserted mid-instruction abandons that instruction: no RF_WE or PC_WRITE is emitted after RST_F falls.
- Outputs are combinational decodes of the present state plus OPCODE/MM/STAT. Default value of every strobe is 0, and ALU_OP defaults to 00, unless listed below. All outputs take their defaults in START0, START1 and HALT, except as listed.
  - PC_RST: 1 in START0 and START1, and also 1 whenever RST_F is low.
  - FETCH: PC_WRITE = 1, PC_SEL = 0.
  - EXECUTE, ALU opcode: ALU_OP = 00 if MM == 0; 01 if MM == 8; 11 for any other MM.
  - EXECUTE, LOD/STR/BRR: ALU_OP = 10.
  - EXECUTE, BRA/BNE: ALU_OP = 11.
  - BR_SEL: 1 in EXECUTE, MEM and WRITEBACK when OPCODE == BRR, else 0.
  - MEM, LOD or STR: MEM_REQ = 1 in every cycle spent in MEM. MEM_WE = MEM_REQ and (OPCODE == STR).
  - WRITEBACK, ALU opcode: RF_WE = 1, WB_SEL = 0, RD_SEL = (MM == 0).
  - WRITEBACK, LOD: RF_WE = 1, WB_SEL = 1, RD_SEL = 1.
- Branch condition, with m = MM[STW-1:0]:
  - BRA/BRR are taken when (STAT & m) == m; m = 0 means unconditional.
  - BNE is taken when (STAT & m) == 0.
  - WRITEBACK with a taken branch: PC_SEL = 1 and PC_WRITE = 1.
  - WRITEBACK with a not-taken branch: PC_SEL = 0 and PC_WRITE = 0.
- HALTED = 1 exactly while in HALT. HLT does not increment INSTR_CNT.
- INSTR_CNT increments by 1 on each rising edge leaving WRITEBACK and wraps modulo 2^CNTW.
- Outputs must be glitch-tolerant but need not be registered. STAT is sampled only in WRITEBACK.

Test Plan:
1. Reset: hold RST_F = 0 for 3 cycles, then release -> STATE = 0 and PC_RST = 1 during reset; STATE goes 0, 1, 2; PC_WRITE = 1 in FETCH; INSTR_CNT = 0.
2. ALU reg then imm: OPCODE = 8, MM = 0 -> ALU_OP = 00 in EXECUTE; RF_WE = 1, RD_SEL = 1, WB_SEL = 0 in WRITEBACK. Then MM = 8 -> ALU_OP = 01, RD_SEL = 0. Each instruction takes 5 cycles FETCH..WRITEBACK; INSTR_CNT = 2 afterwards.
3. LOD with stall: OPCODE = 1, MEM_RDY low for 3 cycles -> MEM lasts 4 cycles with MEM_REQ = 1 and MEM_WE = 0 throughout; WRITEBACK then gives RF_WE = 1, WB_SEL = 1. STR with MEM_RDY = 1 -> MEM_WE = 1 for 1 cycle and RF_WE = 0. With MEM_WAIT_EN = 0, MEM is always 1 cycle regardless of MEM_RDY.
4. Branches:
   - BNE, MM = 4'b0001, STAT = 0001 -> not taken: PC_WRITE = 0 in WRITEBACK.
   - BNE, STAT = 0000 -> taken: PC_SEL = 1, PC_WRITE = 1.
   - BRR, MM = 0 -> BR_SEL = 1 and taken.
5. Halt: OPCODE = 15 in DECODE -> STATE = 7 and HALTED = 1 for 20+ cycles; no strobes; INSTR_CNT unchanged. Reset pulse -> START0.
6. Reset mid-MEM during a stalled STR, then counter wrap with CNTW = 2 -> MEM_REQ/MEM_WE drop immediately, STATE = 0 asynchronously. After 5 retired NOOPs, INSTR_CNT = 1.
